// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle instruction controller.
//   - state_t     : controller FSM states
//   - op_class_t  : execution path an opcode takes through the FSM
//   - OP_*        : 4-bit opcode values
//   - ALU_*       : ALU operation encodings driven on alu_op
//   - FLG_*       : bit positions inside dec_flags
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_ALU_WAIT,
      ST_MEM,
      ST_WB
   } state_t;

   typedef enum logic [2:0] {
      CLS_SKIP,    // DECODE straight to WB
      CLS_SINGLE,  // EXEC then WB
      CLS_ALU,     // EXEC, multi-cycle ALU wait, WB
      CLS_LOAD,    // EXEC, memory read, WB
      CLS_STORE    // EXEC, memory write, WB
   } op_class_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_DIV  = 4'h6;
   localparam logic [3:0] OP_JAL  = 4'h7;
   localparam logic [3:0] OP_CMP  = 4'h8;
   localparam logic [3:0] OP_MOV  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_LI   = 4'hB;
   localparam logic [3:0] OP_LW   = 4'hC;
   localparam logic [3:0] OP_SW   = 4'hD;
   localparam logic [3:0] OP_SLT  = 4'hE;
   localparam logic [3:0] OP_SGT  = 4'hF;

   localparam int ALU_CODE_W = 3;
   localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 3'b000;
   localparam logic [ALU_CODE_W-1:0] ALU_MUL  = 3'b001;
   localparam logic [ALU_CODE_W-1:0] ALU_AND  = 3'b010;
   localparam logic [ALU_CODE_W-1:0] ALU_OR   = 3'b011;
   localparam logic [ALU_CODE_W-1:0] ALU_DIV  = 3'b100;
   localparam logic [ALU_CODE_W-1:0] ALU_PASS = 3'b111;

   localparam int FLAG_W         = 7;
   localparam int FLG_REG_DST    = 6;
   localparam int FLG_ALU_SRC    = 5;
   localparam int FLG_JUMP       = 4;
   localparam int FLG_JAL        = 3;
   localparam int FLG_CMP        = 2;
   localparam int FLG_MOV        = 1;
   localparam int FLG_MEM_TO_REG = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode    in   OPCODE_W  raw opcode
//   alu_op    out  3         ALU operation code
//   dec_flags out  7         {reg_dst, alu_src, jump, jal, cmp, mov, mem_to_reg}
//   legal     out  1         no opcode bit above bit 3 is set
//   op_class  out  class     execution path through the controller FSM
//   wb_en     out  1         instruction writes the register file in WB
// Illegal opcodes decode to all-zero controls so nothing leaks onto the bus.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0]   opcode,
   output logic [ALU_CODE_W-1:0] alu_op,
   output logic [FLAG_W-1:0]     dec_flags,
   output logic                  legal,
   output op_class_t             op_class,
   output logic                  wb_en
);

   always_comb begin
      alu_op    = ALU_ADD;
      dec_flags = '0;
      op_class  = CLS_SINGLE;
      wb_en     = 1'b0;
      legal     = ((opcode >> 4) == '0);

      case (opcode[3:0])
         OP_NOP: begin
            op_class = CLS_SKIP;
         end
         OP_ADD: begin
            dec_flags[FLG_REG_DST] = 1'b1;
            wb_en                  = 1'b1;
         end
         OP_ADDI: begin
            dec_flags[FLG_ALU_SRC] = 1'b1;
            wb_en                  = 1'b1;
         end
         OP_MUL: begin
            alu_op                 = ALU_MUL;
            dec_flags[FLG_REG_DST] = 1'b1;
            op_class               = CLS_ALU;
            wb_en                  = 1'b1;
         end
         OP_AND: begin
            alu_op                 = ALU_AND;
            dec_flags[FLG_REG_DST] = 1'b1;
            wb_en                  = 1'b1;
         end
         OP_OR: begin
            alu_op                 = ALU_OR;
            dec_flags[FLG_REG_DST] = 1'b1;
            wb_en                  = 1'b1;
         end
         OP_DIV: begin
            alu_op                 = ALU_DIV;
            dec_flags[FLG_REG_DST] = 1'b1;
            op_class               = CLS_ALU;
            wb_en                  = 1'b1;
         end
         OP_JAL: begin
            alu_op              = ALU_PASS;
            dec_flags[FLG_JUMP] = 1'b1;
            dec_flags[FLG_JAL]  = 1'b1;
            wb_en               = 1'b1;
         end
         OP_CMP: begin
            dec_flags[FLG_REG_DST] = 1'b1;
            dec_flags[FLG_CMP]     = 1'b1;
            wb_en                  = 1'b1;
         end
         OP_MOV: begin
            alu_op                 = ALU_PASS;
            dec_flags[FLG_REG_DST] = 1'b1;
            dec_flags[FLG_MOV]     = 1'b1;
            wb_en                  = 1'b1;
         end
         OP_JMP: begin
            alu_op              = ALU_PASS;
            dec_flags[FLG_JUMP] = 1'b1;
            op_class            = CLS_SKIP;
         end
         OP_LI: begin
            alu_op                 = ALU_PASS;
            dec_flags[FLG_ALU_SRC] = 1'b1;
            wb_en                  = 1'b1;
         end
         OP_LW: begin
            dec_flags[FLG_ALU_SRC]    = 1'b1;
            dec_flags[FLG_MEM_TO_REG] = 1'b1;
            op_class                  = CLS_LOAD;
            wb_en                     = 1'b1;
         end
         OP_SW: begin
            dec_flags[FLG_ALU_SRC] = 1'b1;
            op_class               = CLS_STORE;
         end
         OP_SLT, OP_SGT: begin
            dec_flags[FLG_REG_DST] = 1'b1;
            dec_flags[FLG_CMP]     = 1'b1;
            wb_en                  = 1'b1;
         end
      endcase

      if (!legal) begin
         alu_op    = '0;
         dec_flags = '0;
         op_class  = CLS_SKIP;
         wb_en     = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencing controller.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   instr_valid/opcode        instruction offer; instr_ready accepts it
//   alu_op, dec_flags         decoded controls, held for the instruction
//   alu_start / alu_done      multi-cycle ALU handshake
//   mem_rd, mem_wr / mem_ack  memory request and completion
//   reg_wr, pc_wr             one-cycle write-back strobes
//   illegal, bus_err          one-cycle error pulses
//   busy                      controller is not idle
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | instr_ready high, waiting for instr_valid
// DECODE    | decoded controls visible; illegal opcodes abort from here
// EXEC      | execute; alu_start pulses for MUL/DIV
// ALU_WAIT  | wait for alu_done, bounded by MAX_WAIT cycles
// MEM       | hold mem_rd/mem_wr until mem_ack, bounded by MAX_WAIT cycles
// WB        | one cycle: pc_wr, plus reg_wr for writing opcodes
//
// Every output is a register loaded from the state being entered, so each
// strobe lines up exactly with the state it belongs to.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int ALU_OP_W = 3,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                instr_ready,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [FLAG_W-1:0]   dec_flags,
   output logic                alu_start,
   input  logic                alu_done,
   output logic                mem_rd,
   output logic                mem_wr,
   input  logic                mem_ack,
   output logic                reg_wr,
   output logic                pc_wr,
   output logic                illegal,
   output logic                bus_err,
   output logic                busy
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   // Count value seen during the last permitted wait cycle.
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(MAX_WAIT - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
   op_class_t               cls_q;
   logic                    wb_en_q;
   logic                    legal_q;

   logic [ALU_CODE_W-1:0]   dec_alu;
   logic [FLAG_W-1:0]       dec_flg;
   logic                    dec_legal;
   op_class_t               dec_cls;
   logic                    dec_wb;

   logic                    hs;
   logic                    timeout;
   logic                    ready_d, start_d, rd_d, wr_d, reg_wr_d, pc_wr_d, illegal_d;

   ctrl_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .opcode    (opcode),
      .alu_op    (dec_alu),
      .dec_flags (dec_flg),
      .legal     (dec_legal),
      .op_class  (dec_cls),
      .wb_en     (dec_wb)
   );

   assign hs = (state_q == ST_IDLE) && instr_valid && instr_ready;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      timeout    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (hs) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (!legal_q)                state_d = ST_IDLE;
            else if (cls_q == CLS_SKIP)  state_d = ST_WB;
            else                         state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (cls_q)
               CLS_ALU:             state_d = ST_ALU_WAIT;
               CLS_LOAD, CLS_STORE: state_d = ST_MEM;
               default:             state_d = ST_WB;
            endcase
         end
         // Completion is tested before the terminal count so a done/ack in
         // the last permitted cycle still completes the instruction.
         ST_ALU_WAIT: begin
            if (alu_done) begin
               state_d = ST_WB;
            end else if (wait_cnt_q == CNT_TC) begin
               state_d = ST_IDLE;
               timeout = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_MEM: begin
            if (mem_ack) begin
               state_d = ST_WB;
            end else if (wait_cnt_q == CNT_TC) begin
               state_d = ST_IDLE;
               timeout = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d   = (state_d == ST_IDLE);
      start_d   = (state_d == ST_EXEC) && (cls_q == CLS_ALU);
      rd_d      = (state_d == ST_MEM)  && (cls_q == CLS_LOAD);
      wr_d      = (state_d == ST_MEM)  && (cls_q == CLS_STORE);
      pc_wr_d   = (state_d == ST_WB);
      reg_wr_d  = (state_d == ST_WB)   && wb_en_q;
      illegal_d = hs && !dec_legal;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         cls_q       <= CLS_SKIP;
         wb_en_q     <= 1'b0;
         legal_q     <= 1'b0;
         instr_ready <= 1'b0;
         busy        <= 1'b0;
         alu_op      <= '0;
         dec_flags   <= '0;
         alu_start   <= 1'b0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         reg_wr      <= 1'b0;
         pc_wr       <= 1'b0;
         illegal     <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         instr_ready <= ready_d;
         busy        <= !ready_d;
         alu_start   <= start_d;
         mem_rd      <= rd_d;
         mem_wr      <= wr_d;
         reg_wr      <= reg_wr_d;
         pc_wr       <= pc_wr_d;
         illegal     <= illegal_d;
         bus_err     <= timeout;
         if (hs) begin
            // Only the accepted opcode matters; later changes are ignored.
            cls_q     <= dec_cls;
            wb_en_q   <= dec_wb;
            legal_q   <= dec_legal;
            alu_op    <= ALU_OP_W'(dec_alu);
            dec_flags <= dec_flg;
         end else if (state_d == ST_IDLE) begin
            alu_op    <= '0;
            dec_flags <= '0;
         end
      end
   end

endmodule
